// File: rtl/adc_serial_capture.sv
// Periodic 16-bit serial ADC frame master; result published 33*CLK_DIV cycles after cs_n falls.
// ready is a level held READY_HOLD cycles per sample; no backpressure, the sample timer paces frames.
module adc_serial_capture #(
    parameter int CLK_DIV       = 4,
    parameter int DATA_BITS     = 12,
    parameter int SAMPLE_PERIOD = 1000,
    parameter int READY_HOLD    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        sdata,
    output logic        cs_n,
    output logic        sclk,
    output logic [15:0] data,
    output logic        ready,
    output logic        busy
);

    localparam int              TW         = $clog2(SAMPLE_PERIOD + 1);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(SAMPLE_PERIOD - 1);
    localparam logic [7:0]      DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0]      HOLD_LAST  = 8'(READY_HOLD - 1);
    localparam logic [15:0]     DATA_MASK  = 16'hFFFF >> (16 - DATA_BITS);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, PUBLISH} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [7:0]    div_cnt, div_cnt_nxt;
    logic [3:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]    hold_cnt, hold_cnt_nxt;
    logic [15:0]   shift, shift_nxt;
    logic [15:0]   data_nxt;
    logic          cs_n_nxt, sclk_nxt, ready_nxt;
    logic          tick;

    always_comb begin
        state_nxt    = state;
        div_cnt_nxt  = div_cnt + 8'd1;
        bit_cnt_nxt  = bit_cnt;
        hold_cnt_nxt = hold_cnt;
        shift_nxt    = shift;
        data_nxt     = data;
        cs_n_nxt     = cs_n;
        sclk_nxt     = sclk;
        ready_nxt    = ready;
        tick         = (div_cnt == DIV_LAST);

        if (!enable)
            timer_nxt = '0;
        else if (timer == TIMER_LAST)
            timer_nxt = '0;
        else
            timer_nxt = timer + 1'b1;

        if (tick)
            div_cnt_nxt = '0;

        case (state)
            IDLE: begin
                div_cnt_nxt = '0;
                // A start coinciding with a busy FSM is simply lost, never queued.
                if (enable && timer == '0) begin
                    cs_n_nxt  = 1'b0;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    sclk_nxt    = 1'b0;
                    bit_cnt_nxt = '0;
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (!sclk) begin
                        // Sample on the edge that raises sclk; the ADC changed sdata after the fall.
                        sclk_nxt    = 1'b1;
                        shift_nxt   = {shift[14:0], sdata};
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15)
                            state_nxt = HOLD;
                    end else begin
                        sclk_nxt = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    cs_n_nxt     = 1'b1;
                    data_nxt     = shift & DATA_MASK;
                    ready_nxt    = 1'b1;
                    hold_cnt_nxt = '0;
                    state_nxt    = PUBLISH;
                end
            end
            PUBLISH: begin
                div_cnt_nxt = '0;
                if (hold_cnt == HOLD_LAST) begin
                    ready_nxt = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    hold_cnt_nxt = hold_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            timer    <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            hold_cnt <= '0;
            shift    <= '0;
            data     <= '0;
            cs_n     <= 1'b1;
            sclk     <= 1'b1;
            ready    <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            div_cnt  <= div_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            hold_cnt <= hold_cnt_nxt;
            shift    <= shift_nxt;
            data     <= data_nxt;
            cs_n     <= cs_n_nxt;
            sclk     <= sclk_nxt;
            ready    <= ready_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_adc_serial_capture.sv
// Bench for adc_serial_capture: two lockstep instances (12-bit and 16-bit results) fed by one ADC model.
module tb_adc_serial_capture;

    localparam int CLK_DIV       = 4;
    localparam int SAMPLE_PERIOD = 1000;
    localparam int READY_HOLD    = 4;
    localparam int FRAME_CYC     = 33 * CLK_DIV;

    logic        clk, reset, enable, sdata;
    logic        cs_n0, sclk0, ready0, busy0;
    logic [15:0] data0;
    logic        cs_n1, sclk1, ready1, busy1;
    logic [15:0] data1;

    typedef struct {
        logic [15:0] d12;
        logic [15:0] d16;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] word_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int pubs        = 0;
    int frames      = 0;
    int run_id      = 0;

    adc_serial_capture #(
        .CLK_DIV(CLK_DIV), .DATA_BITS(12), .SAMPLE_PERIOD(SAMPLE_PERIOD), .READY_HOLD(READY_HOLD)
    ) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .sdata(sdata),
        .cs_n(cs_n0), .sclk(sclk0), .data(data0), .ready(ready0), .busy(busy0)
    );

    adc_serial_capture #(
        .CLK_DIV(CLK_DIV), .DATA_BITS(16), .SAMPLE_PERIOD(SAMPLE_PERIOD), .READY_HOLD(READY_HOLD)
    ) u_dut16 (
        .clk(clk), .reset(reset), .enable(enable), .sdata(sdata),
        .cs_n(cs_n1), .sclk(sclk1), .data(data1), .ready(ready1), .busy(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ADC: MSB driven after the first sclk fall, one new bit per fall; the expected result is pushed at cs_n fall.
    initial begin : adc_model
        logic [15:0] word;
        exp_t        e;
        sdata = 1'b0;
        forever begin
            @(negedge cs_n0);
            if (word_q.size() > 0) word = word_q.pop_front();
            else                   word = 16'($urandom());
            e.d12 = word % 16'd4096;
            e.d16 = word;
            exp_q.push_back(e);
            for (int b = 15; b >= 0; b--) begin
                @(negedge sclk0 or posedge cs_n0);
                if (cs_n0) break;
                #1 sdata = word[b];
            end
        end
    end

    logic        prev_cs = 1'b1, prev_sclk = 1'b1, prev_ready = 1'b0, active = 1'b0;
    logic [15:0] prev_d0 = '0, prev_d1 = '0;
    logic [6:0]  viol;
    int          t0 = 0, rises = 0, rlen = 0, last_run = -1;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (!reset) begin
            active = 1'b0;
        end else begin
            if (prev_cs && !cs_n0) begin
                if (last_run == run_id) chk("start_period", cyc - t0, SAMPLE_PERIOD);
                t0       = cyc;
                last_run = run_id;
                rises    = 0;
                active   = 1'b1;
                frames   = frames + 1;
            end
            if (!prev_sclk && sclk0) begin
                rises = rises + 1;
                chk("sclk_rise_cycle", cyc - t0, 2 * CLK_DIV * rises);
            end
            if (ready0 && !prev_ready) begin
                chk("ready_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("data12", 32'(data0), 32'(mon_e.d12));
                    chk("data16", 32'(data1), 32'(mon_e.d16));
                    chk("publish_cycle", cyc - t0, FRAME_CYC);
                    chk("sclk_rises", rises, 16);
                end
                rlen = 1;
                pubs = pubs + 1;
            end else if (ready0) begin
                rlen = rlen + 1;
            end
            if (prev_ready && !ready0) begin
                chk("ready_len", rlen, READY_HOLD);
                active = 1'b0;
            end
            viol[0] = cs_n0 && !sclk0;
            viol[1] = (data0 != prev_d0) && !(ready0 && !prev_ready);
            viol[2] = (data1 != prev_d1) && !(ready0 && !prev_ready);
            viol[3] = {cs_n1, sclk1, ready1, busy1} != {cs_n0, sclk0, ready0, busy0};
            viol[4] = busy0 != active;
            viol[5] = (data0[15:12] != 4'd0) || (data0[11:0] != data1[11:0]);
            viol[6] = ready0 && !cs_n0;
            chk("protocol", 32'(viol), 0);
        end
        prev_cs    = cs_n0;
        prev_sclk  = sclk0;
        prev_ready = ready0;
        prev_d0    = data0;
        prev_d1    = data1;
    end

    task automatic wait_pubs(input int target, input int budget);
        int n = 0;
        while (pubs < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_pubs", 32'(pubs >= target), 1);
    endtask

    task automatic wait_cs_low(input int budget);
        int n = 0;
        while (cs_n0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_cs_low", 32'(!cs_n0), 1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_cs_n"},  32'(cs_n0),  1);
        chk({tag, "_sclk"},  32'(sclk0),  1);
        chk({tag, "_ready"}, 32'(ready0), 0);
        chk({tag, "_busy"},  32'(busy0),  0);
        chk({tag, "_data"},  32'(data0),  0);
        chk({tag, "_data16"}, 32'(data1), 0);
    endtask

    initial begin : stimulus
        int f;
        int n;
        reset  = 1'b0;
        enable = 1'b0;
        word_q = '{16'hFABC, 16'h0001, 16'h0FFF, 16'hA5C3, 16'h0123, 16'h0123, 16'h0456};
        repeat (3) @(negedge clk);
        chk_reset_state("reset");

        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_disabled_cs_n", 32'(cs_n0), 1);
        enable = 1'b1;
        @(negedge clk);
        chk("first_start_cs_n", 32'(cs_n0), 0);
        chk("first_start_busy", 32'(busy0), 1);
        wait_pubs(4, 5000);

        // Reset 60 cycles into a frame: partial frame discarded.
        wait_cs_low(2000);
        repeat (60) @(posedge clk);
        #2 reset = 1'b0;
        run_id = run_id + 1;
        #1;
        exp_q.delete();
        chk_reset_state("midframe_reset");
        repeat (3) @(negedge clk);
        chk("no_ready_in_reset", 32'(pubs), 4);
        reset = 1'b1;
        @(negedge clk);
        chk("restart_cs_n", 32'(cs_n0), 0);
        wait_pubs(5, 2000);

        // enable dropped 40 cycles into a frame: frame completes, then silence.
        wait_cs_low(2000);
        repeat (40) @(posedge clk);
        #2 enable = 1'b0;
        run_id = run_id + 1;
        wait_pubs(6, 2000);
        f = frames;
        repeat (3 * SAMPLE_PERIOD) @(negedge clk);
        chk("disabled_no_frames", frames, f);
        chk("disabled_cs_n", 32'(cs_n0), 1);

        enable = 1'b1;
        @(negedge clk);
        chk("reenable_start_cs_n", 32'(cs_n0), 0);
        wait_pubs(16, 12 * SAMPLE_PERIOD);

        enable = 1'b0;
        n = 0;
        while (busy0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        chk("drain_idle", 32'(busy0), 0);
        chk("drain_queue", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
